serial_to_parallel: RTL and testbench

Deserializing receiver for the 8x serial link. It takes the 1-bit MSB-first stream produced by the link serializer and finds word alignment by locking onto the idle word 0xBC. Once locked, it presents each received byte on an 8-bit registered bus with a valid flag. It sits at the receive end of the link, clocked by `clk_8f` (one bit per cycle).

---
 rtl/serial_to_parallel_pkg.sv | 24 ++
 rtl/serial_to_parallel.sv | 131 +++++++++++++
 tb/tb_serial_to_parallel.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_to_parallel_pkg
//  Purpose  : Shared 8x serial link definitions. These are the idle/comma
//             word, the word width and the receiver state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_to_parallel_pkg;

    // Width of one link word
    localparam int WORD_WIDTH = 8;

    // Idle/comma word, also emitted by the link serializer
    localparam logic [WORD_WIDTH-1:0] IDLE_WORD = 8'hBC;

    // Receiver alignment state
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
//  Module   : serial_to_parallel
//  Purpose  : Deserializing receiver for the 8x serial link. It locks word
//             alignment onto the idle word and then presents each non-idle
//             byte on a registered bus with a valid flag.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel
    import serial_to_parallel_pkg::*;
#(
    parameter logic [7:0]  IDLE_WORD  = serial_to_parallel_pkg::IDLE_WORD,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       word_strobe,
    output logic       active
);

    localparam logic [3:0] c_lock_count = 4'(LOCK_COUNT);

    // Only the 7 most recent bits are stored. The 8th bit of every
    // candidate word is the bit currently on data_in.
    rx_state_t              r_state;
    logic [WORD_WIDTH-2:0]  r_sr;
    logic [2:0]             r_cnt;
    logic [3:0]             r_idle_cnt;

    logic [WORD_WIDTH-1:0]  w_sr_next;
    logic                   w_is_idle;
    logic                   w_boundary;
    rx_state_t              w_state_next;
    logic [2:0]             w_cnt_next;
    logic [3:0]             w_idle_cnt_next;
    logic [3:0]             w_idle_cnt_inc;
    logic [7:0]             w_data_next;
    logic                   w_valid_next;
    logic                   w_strobe_next;

    // Next-state decode for the shifter, bit counter, lock FSM and output bus
    always_comb begin
        w_sr_next       = {r_sr, data_in};
        w_is_idle       = (w_sr_next == IDLE_WORD);
        w_boundary      = (r_state != SEARCH) && (r_cnt == 3'd7);
        w_idle_cnt_inc  = r_idle_cnt + 4'd1;

        w_state_next    = r_state;
        w_cnt_next      = r_cnt + 3'd1;
        w_idle_cnt_next = r_idle_cnt;
        w_data_next     = data_out;
        w_valid_next    = valid_out;
        w_strobe_next   = 1'b0;

        case (r_state)
            SEARCH: begin
                // Counter parks until a candidate idle word sets the phase
                w_cnt_next = r_cnt;
                if (w_is_idle) begin
                    w_cnt_next      = 3'd0;
                    w_idle_cnt_next = 4'd1;
                    w_state_next    = (c_lock_count == 4'd1) ? ACTIVE : ALIGN;
                end
            end

            ALIGN: begin
                if (w_boundary) begin
                    if (w_is_idle) begin
                        w_idle_cnt_next = (r_idle_cnt >= c_lock_count) ?
                                          c_lock_count : w_idle_cnt_inc;
                        if (w_idle_cnt_inc >= c_lock_count) begin
                            w_state_next = ACTIVE;
                        end
                    end else begin
                        // Wrong phase guess: drop back and hunt again from
                        // the next bit. This word is not re-checked.
                        w_state_next    = SEARCH;
                        w_idle_cnt_next = 4'd0;
                    end
                end
            end

            ACTIVE: begin
                // Once locked, the receiver stays locked until reset
                if (w_boundary) begin
                    w_strobe_next = 1'b1;
                    if (w_is_idle) begin
                        w_valid_next = 1'b0;
                    end else begin
                        w_data_next  = w_sr_next;
                        w_valid_next = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next    = SEARCH;
                w_cnt_next      = 3'd0;
                w_idle_cnt_next = 4'd0;
            end
        endcase
    end

    // State register for shifter, counter, FSM and all registered outputs
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            r_state     <= SEARCH;
            r_sr        <= '0;
            r_cnt       <= 3'd0;
            r_idle_cnt  <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            word_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_sr_next[WORD_WIDTH-2:0];
            r_cnt       <= w_cnt_next;
            r_idle_cnt  <= w_idle_cnt_next;
            data_out    <= w_data_next;
            valid_out   <= w_valid_next;
            word_strobe <= w_strobe_next;
            active      <= (w_state_next == ACTIVE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_to_parallel
//  Purpose  : Directed self-checking bench for serial_to_parallel. A second
//             instance built with LOCK_COUNT = 1 shares the same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;

    logic       clk_8f = 1'b0;
    logic       reset  = 1'b0;
    logic       data_in = 1'b0;

    logic [7:0] data_out;
    logic       valid_out;
    logic       word_strobe;
    logic       active;

    logic [7:0] data_out1;
    logic       valid_out1;
    logic       word_strobe1;
    logic       active1;

    int checks   = 0;
    int failures = 0;
    int strobe_count = 0;

    serial_to_parallel #(
        .IDLE_WORD  (8'hBC),
        .LOCK_COUNT (4)
    ) u_dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .word_strobe (word_strobe),
        .active      (active)
    );

    serial_to_parallel #(
        .IDLE_WORD  (8'hBC),
        .LOCK_COUNT (1)
    ) u_dut_lock1 (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out1),
        .valid_out   (valid_out1),
        .word_strobe (word_strobe1),
        .active      (active1)
    );

    // Bit clock
    always #5 clk_8f = ~clk_8f;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one bit, let the DUT sample it, then observe 1 time unit later
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_8f);
        #1;
        if (word_strobe) strobe_count++;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("rst_data",   data_out,          8'h00);
        check("rst_valid",  {7'd0, valid_out}, 8'h00);
        check("rst_strobe", {7'd0, word_strobe}, 8'h00);
        check("rst_active", {7'd0, active},    8'h00);
        reset = 1'b1;

        // ---------------- lock, then 0x5A, 0xC3 ----------------
        send_word(8'hBC);
        check("lock_bc1_active", {7'd0, active}, 8'h00);
        send_word(8'hBC);
        send_word(8'hBC);
        check("lock_bc3_active", {7'd0, active}, 8'h00);
        send_word(8'hBC);
        check("lock_bc4_active", {7'd0, active}, 8'h01);
        check("lock_bc4_strobe", {7'd0, word_strobe}, 8'h00);
        send_word(8'hBC);
        check("idle5_strobe", {7'd0, word_strobe}, 8'h01);
        check("idle5_valid",  {7'd0, valid_out},   8'h00);
        send_word(8'h5A);
        check("d5a_data",   data_out,            8'h5A);
        check("d5a_valid",  {7'd0, valid_out},   8'h01);
        check("d5a_strobe", {7'd0, word_strobe}, 8'h01);
        send_bit(1'b1);
        check("mid_strobe", {7'd0, word_strobe}, 8'h00);
        check("mid_valid",  {7'd0, valid_out},   8'h01);
        check("mid_data",   data_out,            8'h5A);
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] w;
            w = 8'hC3;
            send_bit(w[i]);
        end
        check("dc3_data",   data_out,            8'hC3);
        check("dc3_strobe", {7'd0, word_strobe}, 8'h01);

        // ---------------- 0x3C, idle, 0x7E in ACTIVE ----------------
        strobe_count = 0;
        send_word(8'h3C);
        check("d3c_data",  data_out,          8'h3C);
        check("d3c_valid", {7'd0, valid_out}, 8'h01);
        send_word(8'hBC);
        check("idle_valid", {7'd0, valid_out}, 8'h00);
        check("idle_hold",  data_out,          8'h3C);
        send_word(8'h7E);
        check("d7e_data",  data_out,          8'h7E);
        check("d7e_valid", {7'd0, valid_out}, 8'h01);
        check("strobe_cnt3", 8'(strobe_count), 8'd3);

        // ---------------- reset mid-word ----------------
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b0;
        send_bit(1'b0);
        check("mrst_data",   data_out,            8'h00);
        check("mrst_valid",  {7'd0, valid_out},   8'h00);
        check("mrst_strobe", {7'd0, word_strobe}, 8'h00);
        check("mrst_active", {7'd0, active},      8'h00);
        reset = 1'b1;

        // ---------------- 3 idles, 0x00, 4 idles, 0x11 ----------------
        send_word(8'hBC);
        send_word(8'hBC);
        send_word(8'hBC);
        check("relock3_active", {7'd0, active}, 8'h00);
        send_word(8'h00);
        check("break_active", {7'd0, active}, 8'h00);
        send_word(8'hBC);
        send_word(8'hBC);
        send_word(8'hBC);
        check("relock_b3_active", {7'd0, active}, 8'h00);
        send_word(8'hBC);
        check("relock_b4_active", {7'd0, active}, 8'h01);
        send_word(8'h11);
        check("d11_data",  data_out,          8'h11);
        check("d11_valid", {7'd0, valid_out}, 8'h01);

        // ---------------- misaligned start ----------------
        reset = 1'b0;
        send_bit(1'b0);
        reset = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_word(8'hBC);
        send_word(8'hBC);
        send_word(8'hBC);
        check("mis_b3_active", {7'd0, active}, 8'h00);
        send_word(8'hBC);
        check("mis_b4_active", {7'd0, active}, 8'h01);
        send_word(8'hA5);
        check("da5_data",   data_out,            8'hA5);
        check("da5_valid",  {7'd0, valid_out},   8'h01);
        check("da5_strobe", {7'd0, word_strobe}, 8'h01);

        // ---------------- LOCK_COUNT = 1 instance ----------------
        reset = 1'b0;
        send_bit(1'b0);
        check("l1_rst_active", {7'd0, active1}, 8'h00);
        reset = 1'b1;
        send_word(8'hBC);
        check("l1_active", {7'd0, active1},    8'h01);
        check("l1_valid0", {7'd0, valid_out1}, 8'h00);
        send_word(8'h96);
        check("l1_data",   data_out1,             8'h96);
        check("l1_valid",  {7'd0, valid_out1},    8'h01);
        check("l1_strobe", {7'd0, word_strobe1},  8'h01);
        check("l4_inactive", {7'd0, active},      8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
